// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: read-owner tag, grant bit positions
// and the default starvation threshold.
package mem_arbiter_pkg;

    localparam int unsigned StarveMaxDefault = 4;
    localparam int unsigned StarveCntW       = 4;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GntIf = 0;
    localparam int unsigned GntD  = 1;
    localparam int unsigned GntLd = 2;

    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerIf   = 2'd1,
        OwnerD    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Fixed-priority grant (ld > d > if) with instruction fetch promoted above the
// data port once the starvation flag is set.
module arb_prio
    import mem_arbiter_pkg::*;
(
    input  logic       if_req_i,
    input  logic       d_req_i,
    input  logic       ld_req_i,
    input  logic       if_promote_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (ld_req_i) begin
            gnt_o[GntLd] = 1'b1;
        end else if (if_req_i && (if_promote_i || !d_req_i)) begin
            gnt_o[GntIf] = 1'b1;
        end else if (d_req_i) begin
            gnt_o[GntD] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for fetch, data and loader requesters; tracks which
// requester owns the read data returning one cycle after a granted read.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [StarveCntW-1:0] StarveLimit = StarveCntW'(STARVE_MAX);

    logic [StarveCntW-1:0] starve_cnt_q, starve_cnt_d;
    owner_e                owner_q, owner_d;
    logic [2:0]            gnt_raw, gnt;

    arb_prio u_arb_prio (
        .if_req_i     (if_req),
        .d_req_i      (d_req),
        .ld_req_i     (ld_req),
        .if_promote_i (starve_cnt_q == StarveLimit),
        .gnt_o        (gnt_raw)
    );

    // Reset masks every grant so nothing reaches the RAM during reset
    assign gnt    = reset ? gnt_raw : 3'b000;
    assign if_gnt = gnt[GntIf];
    assign d_gnt  = gnt[GntD];
    assign ld_gnt = gnt[GntLd];

    assign stall = (if_req & ~if_gnt) | (d_req & ~d_gnt);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OwnerNone;
        unique case (gnt)
            3'b001: begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
                owner_d  = OwnerIf;
            end
            3'b010: begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                owner_d   = d_we ? OwnerNone : OwnerD;
            end
            3'b100: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != StarveLimit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            owner_q      <= OwnerNone;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end

    assign if_rvalid = (owner_q == OwnerIf);
    assign d_rvalid  = (owner_q == OwnerD);
    assign rdata     = mem_rdata;

endmodule
